// File: rtl/stream_out_matrix_scheduler.sv
// Round-robin arbiter that shares one matrix streamer (load strobe, then E row-major
// elements) among N requesters and emits per-element id/first/last sideband.
module stream_out_matrix_scheduler #(
  parameter int BITS = 8,
  parameter int R    = 3,
  parameter int C    = 3,
  parameter int N    = 4,
  localparam int E   = R * C,
  localparam int IDW = (N > 2) ? $clog2(N) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic [N-1:0]                         req_valid,
  input  logic [N-1:0][R-1:0][C-1:0][BITS-1:0] req_a,
  output logic [N-1:0]                         req_ready,
  output logic                                 st_in_valid,
  output logic [R-1:0][C-1:0][BITS-1:0]        st_a,
  output logic                                 tag_valid,
  output logic [IDW-1:0]                       tag_id,
  output logic                                 tag_first,
  output logic                                 tag_last,
  output logic                                 busy
);

  localparam int CW = $clog2(E + 1);

  // Handshake: req_ready[i] is a one-cycle pulse, only alongside st_in_valid, meaning
  // req_a[i] was copied to st_a and the streamer loaded it in this same cycle.

  typedef enum logic [1:0] {
    S_DRAIN  = 2'd0,
    S_IDLE   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IDW-1:0] last_grant;
  logic [CW-1:0] tag_k;

  logic           found;
  logic [IDW-1:0] winner;
  logic           can_load;
  logic           issue;

  // Rotating priority: search starts one past the previous winner.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last_grant) + i) % N;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign can_load    = (state == S_IDLE) || ((state == S_STREAM) && (cnt == '0));
  assign issue       = can_load && en && found;
  assign st_in_valid = issue;
  assign st_a        = issue ? req_a[winner] : '0;
  assign req_ready   = issue ? (N'(1) << winner) : '0;
  assign busy        = (state != S_IDLE);

  // DRAIN waits out a streamer that may still be emitting after our reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_DRAIN;
      cnt        <= CW'(E);
      last_grant <= IDW'(N - 1);
    end else if (issue) begin
      state      <= S_STREAM;
      cnt        <= CW'(E - 1);
      last_grant <= winner;
    end else begin
      case (state)
        S_DRAIN, S_STREAM: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        S_IDLE:  state <= S_IDLE;
        default: state <= S_DRAIN;
      endcase
    end
  end

  // Sideband mirrors the streamer: elements 0..E-1 in the E cycles after a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= 1'b0;
      tag_id    <= '0;
      tag_first <= 1'b0;
      tag_last  <= 1'b0;
      tag_k     <= '0;
    end else if (issue) begin
      tag_valid <= 1'b1;
      tag_id    <= winner;
      tag_first <= 1'b1;
      tag_last  <= 1'b0;
      tag_k     <= '0;
    end else if (tag_valid) begin
      tag_first <= 1'b0;
      if (tag_k == CW'(E - 1)) begin
        tag_valid <= 1'b0;
        tag_last  <= 1'b0;
      end else begin
        tag_k    <= tag_k + 1'b1;
        tag_last <= (tag_k == CW'(E - 2));
      end
    end
  end

endmodule
